// File: rtl/shader_dispatch_if.sv
// rtl/shader_dispatch_if.sv - triangle, shader-unit and result signal bundle for shader_dispatch
interface shader_dispatch_if #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 8
);
  localparam int CNT_W = $clog2(NUM_UNITS + 1);

  logic                      tri_valid;
  logic                      tri_ready;
  logic [ID_W-1:0]           tri_id;
  logic [287:0]              tri_p;
  logic [NUM_UNITS-1:0]      unit_start;
  logic [NUM_UNITS-1:0]      unit_sreset;
  logic [NUM_UNITS*288-1:0]  unit_tri;
  logic [NUM_UNITS-1:0]      unit_done;
  logic [NUM_UNITS*4-1:0]    unit_color;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic [3:0]                res_color;
  logic                      res_err;
  logic [CNT_W-1:0]          inflight;

  modport slave (
    input  tri_valid, tri_id, tri_p, unit_done, unit_color, res_ready,
    output tri_ready, unit_start, unit_sreset, unit_tri, res_valid, res_id, res_color, res_err,
           inflight
  );

  modport master (
    output tri_valid, tri_id, tri_p, unit_done, unit_color, res_ready,
    input  tri_ready, unit_start, unit_sreset, unit_tri, res_valid, res_id, res_color, res_err,
           inflight
  );
endinterface

// File: rtl/shader_dispatch.sv
// rtl/shader_dispatch.sv - shares NUM_UNITS shader units across one triangle stream,
// returning tagged colors out of order with a per-unit watchdog.
module shader_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              sreset,
  shader_dispatch_if.slave  bus
);
  localparam int UW    = $clog2(NUM_UNITS);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int CNT_W = $clog2(NUM_UNITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESULT} state_t;

  state_t               r_state [NUM_UNITS];
  state_t               w_state_nxt [NUM_UNITS];
  logic [287:0]         r_tri   [NUM_UNITS];
  logic [ID_W-1:0]      r_id    [NUM_UNITS];
  logic [3:0]           r_color [NUM_UNITS];
  logic [WD_W-1:0]      r_wdog  [NUM_UNITS];
  logic [NUM_UNITS-1:0] r_err;
  logic [NUM_UNITS-1:0] r_start;
  logic [UW-1:0]        r_rr_ptr;
  logic                 r_res_valid;
  logic [UW-1:0]        r_res_unit;
  logic [ID_W-1:0]      r_res_id;
  logic [3:0]           r_res_color;
  logic                 r_res_err;

  logic [NUM_UNITS-1:0] w_idle, w_timeout, w_done_cap, w_launch_sel, w_cand;
  logic                 w_tri_ready, w_accept, w_handshake, w_grant;
  logic [UW-1:0]        w_acc_unit, w_grant_unit, w_ptr_nxt;
  logic [CNT_W-1:0]     w_inflight;

  always_comb begin
    w_inflight = '0;
    w_acc_unit = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_idle[i]    = (r_state[i] == S_IDLE);
      w_timeout[i] = ((r_state[i] == S_LAUNCH) || (r_state[i] == S_RUN)) &&
                     (r_wdog[i] == WD_W'(TIMEOUT - 1));
      w_done_cap[i] = (r_state[i] == S_RUN) && bus.unit_done[i] && !w_timeout[i];
      w_cand[i]    = (r_state[i] == S_RESULT) && !(r_res_valid && (r_res_unit == UW'(i)));
      if (!w_idle[i]) w_inflight = w_inflight + CNT_W'(1);
    end
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (w_idle[i]) w_acc_unit = UW'(i);
    end
    w_tri_ready = (|w_idle) & ~sreset;
    w_accept    = bus.tri_valid & w_tri_ready;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_launch_sel[i] = w_accept && (w_acc_unit == UW'(i));
    end
  end

  // Round robin: scan from the pointer, the lowest offset wins.
  always_comb begin
    w_grant_unit = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (w_cand[(int'(r_rr_ptr) + k) % NUM_UNITS]) w_grant_unit = UW'((int'(r_rr_ptr) + k) % NUM_UNITS);
    end
    w_handshake = r_res_valid & bus.res_ready;
    w_grant     = (!r_res_valid || w_handshake) && (|w_cand);
    w_ptr_nxt   = (w_grant_unit == UW'(NUM_UNITS - 1)) ? '0 : w_grant_unit + UW'(1);
  end

  // First LAUNCH cycle is recognised by the freshly cleared watchdog.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE:   if (w_launch_sel[i]) w_state_nxt[i] = S_LAUNCH;
        S_LAUNCH: begin
          if (w_timeout[i]) w_state_nxt[i] = S_RESULT;
          else if ((r_wdog[i] != '0) && !bus.unit_done[i]) w_state_nxt[i] = S_RUN;
        end
        S_RUN:    if (w_timeout[i] || bus.unit_done[i]) w_state_nxt[i] = S_RESULT;
        S_RESULT: if (w_handshake && (r_res_unit == UW'(i))) w_state_nxt[i] = S_IDLE;
        default:  w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_state[i] <= S_IDLE;
        r_tri[i]   <= '0;
        r_id[i]    <= '0;
        r_color[i] <= '0;
        r_wdog[i]  <= '0;
      end
      r_err       <= '0;
      r_start     <= '0;
      r_rr_ptr    <= '0;
      r_res_valid <= 1'b0;
      r_res_unit  <= '0;
      r_res_id    <= '0;
      r_res_color <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_start <= w_launch_sel;
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_launch_sel[i]) begin
          r_tri[i]  <= bus.tri_p;
          r_id[i]   <= bus.tri_id;
          r_wdog[i] <= '0;
        end else if ((r_state[i] == S_LAUNCH) || (r_state[i] == S_RUN)) begin
          r_wdog[i] <= r_wdog[i] + WD_W'(1);
        end
        if (w_timeout[i]) begin
          r_color[i] <= 4'd0;
          r_err[i]   <= 1'b1;
        end else if (w_done_cap[i]) begin
          r_color[i] <= bus.unit_color[i*4 +: 4];
          r_err[i]   <= 1'b0;
        end
      end
      if (w_grant) begin
        r_res_valid <= 1'b1;
        r_res_unit  <= w_grant_unit;
        r_res_id    <= r_id[w_grant_unit];
        r_res_color <= r_color[w_grant_unit];
        r_res_err   <= r_err[w_grant_unit];
        r_rr_ptr    <= w_ptr_nxt;
      end else if (w_handshake) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.tri_ready   = w_tri_ready;
  assign bus.unit_start  = r_start;
  assign bus.unit_sreset = {NUM_UNITS{sreset}} | w_timeout;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_id      = r_res_id;
  assign bus.res_color   = r_res_color;
  assign bus.res_err     = r_res_err;
  assign bus.inflight    = w_inflight;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit_tri
    assign bus.unit_tri[g*288 +: 288] = r_tri[g];
  end
endmodule

// File: tb/tb_shader_dispatch.sv
// tb/tb_shader_dispatch.sv - randomized bench for shader_dispatch with behavioural shader units
// and a scoreboard of dispatch, watchdog and result rules.
module tb_shader_dispatch;
  localparam int N   = 4;
  localparam int IDW = 8;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic sreset;
  always #5 clk = ~clk;

  shader_dispatch_if #(.NUM_UNITS(N), .ID_W(IDW)) bus ();
  shader_dispatch #(.NUM_UNITS(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .sreset(sreset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // scoreboard: which unit holds which triangle
  bit               busy  [N];
  logic [IDW-1:0]   m_id  [N];
  logic [287:0]     m_tri [N];
  logic [N-1:0]     pend_start;
  logic [IDW-1:0]   id_ctr;
  logic [IDW-1:0]   hs_q[$];

  // shader unit models: 0 idle, 1 busy, 2 finished, 3 hung done-high, 4 hung done-low
  int               ph    [N];
  int               ucnt  [N];
  int               s_cyc [N];
  int               force_l [N];
  logic [3:0]       ucol  [N];
  logic [3:0]       e_col [N];
  bit               e_err [N];
  bit               fin   [N];
  logic [N-1:0]     done_v;
  bit               directed;
  bit               rst_q, prev_hold;
  logic [287:0]     prev_data;

  task automatic check(input string tag, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input bit want_tv, input bit rr, input bit rst);
    logic [N-1:0] to_v;
    logic [287:0] tp;
    int nbusy, u, found;
    bit any_free, acc, hs;
    @(negedge clk);
    cyc++;
    nbusy = 0;
    any_free = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (busy[i]) nbusy++;
      else any_free = 1'b1;
      to_v[i] = ((ph[i] == 3) || (ph[i] == 4)) && (s_cyc[i] + TO - 1 == cyc);
    end
    check("unit_start", 288'(bus.unit_start), 288'(pend_start));
    check("unit_sreset", 288'(bus.unit_sreset), rst_q ? 288'({N{1'b1}}) : 288'(to_v));
    check("tri_ready", 288'(bus.tri_ready), 288'(any_free && !rst_q));
    check("inflight", 288'(bus.inflight), 288'(nbusy));
    if (rst_q) begin
      check("res_valid_rst", 288'(bus.res_valid), 288'(0));
      check("res_fields_rst", 288'({bus.res_id, bus.res_color, bus.res_err}), 288'(0));
      check("unit_tri_rst", 288'(|bus.unit_tri), 288'(0));
    end
    for (int i = 0; i < N; i++) begin
      if (busy[i]) check("unit_tri_hold", bus.unit_tri[i*288 +: 288], m_tri[i]);
    end
    if (prev_hold) begin
      check("res_hold_valid", 288'(bus.res_valid), 288'(1));
      check("res_hold_data", 288'({bus.res_id, bus.res_color, bus.res_err}), prev_data);
    end

    for (int i = 0; i < N; i++) begin
      if (bus.unit_start[i]) begin
        s_cyc[i] = cyc;
        fin[i]   = 1'b0;
        ucol[i]  = 4'($urandom);
        if (directed) begin
          ph[i] = 1; ucnt[i] = force_l[i];
        end else if ($urandom_range(0, 7) == 0) begin
          ph[i] = int'($urandom_range(3, 4));
        end else begin
          ph[i] = 1; ucnt[i] = int'($urandom_range(1, 30));
        end
        e_err[i] = (ph[i] >= 3);
        e_col[i] = (ph[i] >= 3) ? 4'd0 : ucol[i];
        done_v[i] = (ph[i] != 4);
      end else if (bus.unit_sreset[i] && !rst_q) begin
        ph[i] = 0; fin[i] = 1'b1; done_v[i] = 1'b1;
      end else begin
        case (ph[i])
          1: if (ucnt[i] > 0) begin
               done_v[i] = 1'b0; ucnt[i]--;
             end else begin
               done_v[i] = 1'b1; ph[i] = 2; fin[i] = 1'b1;
             end
          4: done_v[i] = 1'b0;
          default: done_v[i] = 1'b1;
        endcase
      end
    end

    hs = bus.res_valid && rr && !rst;
    found = -1;
    if (hs) begin
      for (int i = 0; i < N; i++) if (busy[i] && (m_id[i] == bus.res_id)) found = i;
      check("res_id_known", 288'(found >= 0), 288'(1));
      if (found >= 0) begin
        check("res_after_done", 288'(fin[found]), 288'(1));
        check("res_color", 288'(bus.res_color), 288'(e_col[found]));
        check("res_err", 288'(bus.res_err), 288'(e_err[found]));
        hs_q.push_back(bus.res_id);
      end
    end

    tp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    acc = want_tv && any_free && !rst;
    pend_start = '0;
    if (acc) begin
      u = -1;
      for (int i = N - 1; i >= 0; i--) if (!busy[i]) u = i;
      busy[u] = 1'b1; m_id[u] = id_ctr; m_tri[u] = tp; pend_start[u] = 1'b1;
    end
    if (found >= 0) busy[found] = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        busy[i] = 1'b0; ph[i] = 0; fin[i] = 1'b0; done_v[i] = 1'b1;
      end
      pend_start = '0;
    end

    bus.tri_valid = want_tv;
    bus.tri_id    = id_ctr;
    bus.tri_p     = tp;
    bus.res_ready = rr;
    for (int i = 0; i < N; i++) bus.unit_color[i*4 +: 4] = ucol[i];
    bus.unit_done = done_v;
    sreset        = rst;
    if (acc) id_ctr = id_ctr + 8'd1;
    prev_hold = bus.res_valid && !rr && !rst;
    prev_data = 288'({bus.res_id, bus.res_color, bus.res_err});
    rst_q     = rst;
  endtask

  initial begin
    logic [IDW-1:0] exp_order [4];
    int nb;
    sreset = 1'b1;
    bus.tri_valid = 1'b0; bus.tri_id = '0; bus.tri_p = '0;
    bus.res_ready = 1'b0; bus.unit_done = '1; bus.unit_color = '0;
    for (int i = 0; i < N; i++) begin
      busy[i] = 1'b0; ph[i] = 0; ucnt[i] = 0; s_cyc[i] = -1000; fin[i] = 1'b0;
      ucol[i] = '0; e_col[i] = '0; e_err[i] = 1'b0; m_id[i] = '0; m_tri[i] = '0; force_l[i] = 1;
    end
    done_v = '1; pend_start = '0; id_ctr = 8'h11; directed = 1'b0;
    prev_hold = 1'b0; prev_data = '0;
    repeat (2) @(negedge clk);
    rst_q = 1'b1;

    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);
    end
    for (int k = 0; k < 400; k++) begin
      nb = 0;
      for (int i = 0; i < N; i++) if (busy[i]) nb++;
      if (nb == 0) break;
      step(1'b0, 1'b1, 1'b0);
    end
    nb = 0;
    for (int i = 0; i < N; i++) if (busy[i]) nb++;
    check("drain_empty", 288'(nb), 288'(0));

    // units 1/3 finish together, then 0/2 finish together; results held back at first
    directed = 1'b1;
    force_l[0] = 40; force_l[1] = 12; force_l[2] = 38; force_l[3] = 10;
    step(1'b0, 1'b0, 1'b1);
    hs_q.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);
    exp_order[0] = m_id[1]; exp_order[1] = m_id[3]; exp_order[2] = m_id[0]; exp_order[3] = m_id[2];
    for (int k = 4; k < 24; k++) step(1'b0, 1'b0, 1'b0);
    for (int k = 24; k < 100; k++) step(1'b0, 1'b1, 1'b0);
    check("rr_count", 288'(hs_q.size()), 288'(4));
    for (int k = 0; k < 4; k++) begin
      check("rr_order", 288'((hs_q.size() > k) ? hs_q[k] : 8'hxx), 288'(exp_order[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
